// File: rtl/instr_queue.sv
// instr_queue: fetch-to-decode instruction FIFO; compacts valid fetch lanes into program order.
// Latency: push to deq 1 cycle; 0 cycles from empty when IQ_BYPASS_EN is defined (same-cycle bypass).
// Backpressure: full when free slots < FETCH_NUM (registered count); head is held until deq_ready.
// Optional feature macro: IQ_BYPASS_EN.

package rv32i_types;
  localparam int INSTR_FETCH_NUM = 2;

  typedef struct packed {
    logic        valid;
    logic        br_taken_pred;
    logic [31:0] pc;
    logic [31:0] instr;
  } pc_instr_t;
endpackage

module instr_queue
  import rv32i_types::*;
#(
  parameter int DEPTH     = 16,
  parameter int FETCH_NUM = INSTR_FETCH_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  pc_instr_t [FETCH_NUM-1:0] push_data,
  output logic                      full,
  output pc_instr_t                 deq_data,
  output logic                      deq_valid,
  input  logic                      deq_ready,
  input  logic                      flush,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int LIW = (FETCH_NUM > 1) ? $clog2(FETCH_NUM) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FETCH_C = CW'(FETCH_NUM);

  // Storage and pointers; count is kept separately so full/empty never alias.
  pc_instr_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Lane bookkeeping.
  logic [FETCH_NUM-1:0] lane_vld;
  logic [FETCH_NUM-1:0] first_oh;
  logic [LIW-1:0]       first_idx;
  logic                 any_vld;
  logic [FETCH_NUM-1:0] lane_st;
  logic [PW-1:0]        wr_addr [FETCH_NUM];
  pc_instr_t            wr_dat  [FETCH_NUM];
  logic [CW-1:0]        n_st;

  // Handshake qualifiers.
  logic push_ok;
  logic pop_ok;
  logic byp_vld;
  logic byp_take;

  // Gather lane valids and locate the lowest valid lane (program-order head of the packet).
  always_comb begin
    lane_vld  = '0;
    first_oh  = '0;
    first_idx = '0;
    any_vld   = 1'b0;
    for (int l = 0; l < FETCH_NUM; l++) begin
      lane_vld[l] = push_data[l].valid;
      if (push_data[l].valid && !any_vld) begin
        first_oh[l] = 1'b1;
        first_idx   = LIW'(l);
        any_vld     = 1'b1;
      end
    end
  end

  // Status flags come from the registered count only, so full has no path from deq_ready.
  always_comb begin
    full    = (DEPTH_C - count_q) < FETCH_C;
    empty   = (count_q == '0);
    count   = count_q;
    push_ok = push && !full && !flush;
    pop_ok  = !empty && deq_ready && !flush;
  end

`ifdef IQ_BYPASS_EN
  // From empty, the lowest valid lane is presented to decode in the same cycle.
  assign byp_vld = empty && push && !flush && any_vld;
`else
  // No bypass: deq_valid depends only on registered state.
  assign byp_vld = 1'b0;
`endif
  // A bypassed lane consumed by decode this cycle is never written to storage.
  assign byp_take = byp_vld && deq_ready;

  // Compact the lanes to be stored: each lands at tail plus the number of stored lanes below it.
  always_comb begin
    logic [CW-1:0] acc;
    acc     = '0;
    lane_st = push_ok ? (lane_vld & ~(byp_take ? first_oh : '0)) : '0;
    for (int l = 0; l < FETCH_NUM; l++) begin
      wr_addr[l]       = tail_q + acc[PW-1:0];
      wr_dat[l]        = push_data[l];
      wr_dat[l].valid  = 1'b1;
      if (lane_st[l]) begin
        acc = acc + 1'b1;
      end
    end
    n_st = acc;
  end

  // Pointer and occupancy update; flush wins over any same-cycle push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_ok) begin
        head_d = head_q + 1'b1;
      end
      tail_d  = tail_q + n_st[PW-1:0];
      count_d = count_q + n_st - CW'(pop_ok);
    end
  end

  // Control state, cleared asynchronously so reset discards contents immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry array write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int l = 0; l < FETCH_NUM; l++) begin
      if (lane_st[l]) begin
        mem_q[wr_addr[l]] <= wr_dat[l];
      end
    end
  end

  // Head presentation: stored head, else bypassed lane, else zero.
  always_comb begin
    deq_valid = !empty || byp_vld;
    deq_data  = '0;
    if (!empty) begin
      deq_data = mem_q[head_q];
    end else if (byp_vld) begin
      deq_data       = push_data[first_idx];
      deq_data.valid = 1'b1;
    end
  end

  // Fetch must not push into a full queue; such a packet is dropped.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && full));
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: randomized and directed checks of instr_queue against a queue-based reference model.
// Runs DEPTH=8, FETCH_NUM=2; expectations follow the bypass option when IQ_BYPASS_EN is defined.
// Never pushes while full, so the protocol assertion stays quiet.
module tb_instr_queue;
  import rv32i_types::*;

  localparam int DEPTH = 8;
  localparam int FN    = 2;
`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              push;
  pc_instr_t [FN-1:0] push_data;
  logic              full;
  pc_instr_t         deq_data;
  logic              deq_valid;
  logic              deq_ready;
  logic              flush;
  logic              empty;
  logic [3:0]        count;

  int errors = 0;
  int checks = 0;

  pc_instr_t mq[$];

  instr_queue #(.DEPTH(DEPTH), .FETCH_NUM(FN)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .deq_data  (deq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .flush     (flush),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic pc_instr_t mk(input bit v, input logic [31:0] pc, input bit br, input logic [31:0] ins);
    pc_instr_t e;
    e.valid         = v;
    e.br_taken_pred = br;
    e.pc            = pc;
    e.instr         = ins;
    return e;
  endfunction

  task automatic drive(input bit p, input bit v0, input logic [31:0] pc0,
                       input bit v1, input logic [31:0] pc1, input bit rdy, input bit fl);
    push         = p;
    push_data[0] = mk(v0, pc0, pc0[3], ~pc0);
    push_data[1] = mk(v1, pc1, pc1[3], pc1 ^ 32'h5a5a_0000);
    deq_ready    = rdy;
    flush        = fl;
  endtask

  function automatic bit model_full();
    return (DEPTH - mq.size()) < FN;
  endfunction

  // Compare every DUT output against the model, away from the clock edge.
  task automatic sample();
    int        sz;
    bit        byp;
    bit        anyv;
    pc_instr_t ed;
    @(negedge clk);
    sz   = rst ? 0 : mq.size();
    anyv = push_data[0].valid || push_data[1].valid;
    byp  = BYP && !rst && sz == 0 && push && !flush && anyv;
    ed   = '0;
    if (sz != 0) begin
      ed = mq[0];
    end else if (byp) begin
      ed       = push_data[0].valid ? push_data[0] : push_data[1];
      ed.valid = 1'b1;
    end
    chk("count",     count,     sz);
    chk("empty",     empty,     sz == 0);
    chk("full",      full,      (DEPTH - sz) < FN);
    chk("deq_valid", deq_valid, (sz != 0) || byp);
    chk("deq_data",  deq_data,  ed);
  endtask

  // Advance the model by the queue rules at the clock edge.
  task automatic commit();
    int  pre;
    bit  skip;
    bit  fullp;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      pre   = mq.size();
      fullp = (DEPTH - pre) < FN;
      skip  = BYP && pre == 0 && push && deq_ready;
      if (pre != 0 && deq_ready) void'(mq.pop_front());
      if (push && !fullp) begin
        for (int l = 0; l < FN; l++) begin
          if (push_data[l].valid) begin
            if (skip) begin
              skip = 1'b0;
            end else begin
              pc_instr_t e;
              e       = push_data[l];
              e.valid = 1'b1;
              mq.push_back(e);
            end
          end
        end
      end
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    commit();
  endtask

  initial begin
    logic [31:0] np;
    logic [31:0] exp_pop;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_vld",   deq_valid, 0);
    chk("rst_data",  deq_data, 0);
    chk("rst_full",  full, 0);
    commit();
    rst = 1'b0;

    // Basic two-lane push then two pops.
    drive(1, 1, 32'h6000_0000, 1, 32'h6000_0004, 0, 0);
    sample();
    if (!BYP) chk("nobyp_vld", deq_valid, 0);
    commit();
    drive(0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("t1_count", count, 2);
    chk("t1_vld",   deq_valid, 1);
    chk("t1_pc0",   deq_data.pc, 32'h6000_0000);
    commit();
    sample();
    chk("t1_pc1", deq_data.pc, 32'h6000_0004);
    commit();
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("t1_empty", empty, 1);
    commit();

    // Compaction of sparse packets.
    drive(1, 0, 32'h6000_0000, 1, 32'h6000_0004, 0, 0);
    cyc();
    drive(1, 1, 32'h6000_0008, 0, 32'h6000_000c, 0, 0);
    sample();
    chk("cmp_count", count, 1);
    chk("cmp_pc",    deq_data.pc, 32'h6000_0004);
    commit();
    drive(0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("cmp_count2", count, 2);
    commit();
    sample();
    chk("cmp_pc2", deq_data.pc, 32'h6000_0008);
    commit();

    // Fill to full, pop one, then flush with concurrent push and pop.
    drive(1, 1, 32'h6000_0020, 1, 32'h6000_0024, 0, 0); cyc();
    drive(1, 1, 32'h6000_0028, 1, 32'h6000_002c, 0, 0); cyc();
    drive(1, 1, 32'h6000_0030, 1, 32'h6000_0034, 0, 0); cyc();
    drive(1, 1, 32'h6000_0038, 1, 32'h6000_003c, 0, 0);
    sample();
    chk("fill_count6", count, 6);
    chk("fill_full6",  full, 0);
    commit();
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("fill_count8", count, 8);
    chk("fill_full8",  full, 1);
    commit();
    drive(0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("fill_head", deq_data.pc, 32'h6000_0020);
    commit();
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("fill_count7", count, 7);
    chk("fill_full7",  full, 1);
    commit();
    drive(0, 0, 0, 0, 0, 1, 0); cyc(); cyc();
    drive(1, 1, 32'h6000_0200, 1, 32'h6000_0204, 1, 1);
    sample();
    chk("fl_count5", count, 5);
    commit();
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_vld",   deq_valid, 0);
    commit();
    drive(1, 1, 32'h6000_0100, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 1, 0);
    sample();
    chk("fl_next_pc", deq_data.pc, 32'h6000_0100);
    commit();

    // Steady streaming across pointer wrap: dequeued pcs step by 4.
    np      = 32'h6000_1000;
    exp_pop = 32'h6000_1000;
    for (int i = 0; i < 20; i++) begin
      bit p;
      p = !model_full();
      drive(p, 1, np, 1, np + 32'h4, 1, 0);
      sample();
      if (mq.size() != 0 || (BYP && p)) begin
        chk("steady_pc", deq_data.pc, exp_pop);
        exp_pop = exp_pop + 32'h4;
      end
      commit();
      if (p) np = np + 32'h8;
    end

    // Bypass behaviour from an empty queue.
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    drive(1, 1, 32'h6000_0010, 1, 32'h6000_0014, 1, 0);
    sample();
    if (BYP) begin
      chk("byp_vld", deq_valid, 1);
      chk("byp_pc",  deq_data.pc, 32'h6000_0010);
    end else begin
      chk("byp_vld", deq_valid, 0);
    end
    commit();
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    if (BYP) begin
      chk("byp_count", count, 1);
      chk("byp_head",  deq_data.pc, 32'h6000_0014);
    end else begin
      chk("byp_count", count, 2);
      chk("byp_head",  deq_data.pc, 32'h6000_0010);
    end
    commit();

    // Randomized traffic with occasional flush and mid-operation reset.
    for (int i = 0; i < 1500; i++) begin
      bit r, fl, p;
      r  = ($urandom_range(0, 299) == 0);
      fl = ($urandom_range(0, 24) == 0);
      p  = !r && ($urandom_range(0, 3) != 0) && !model_full();
      rst = r;
      push = p;
      for (int l = 0; l < FN; l++) begin
        push_data[l] = mk(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      deq_ready = 1'($urandom_range(0, 1));
      flush     = fl;
      cyc();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
